spi_host_cmd_arbiter: RTL

Multi-context command front end for the SPI host. It holds one command FIFO per software channel and arbitrates round-robin onto the single core command interface. Chip-select atomicity is preserved: once a channel issues a CSAAT segment, the grant stays on that channel until it issues a non-CSAAT segment. A lock timeout recovers from a stalled channel. It replaces the single-queue path between the register decode and spi_host_core.

---
 rtl/spi_host_cmd_arb_pkg.sv | 35 +++
 rtl/spi_host_cmd_arb_fifo.sv | 55 +++++
 rtl/spi_host_cmd_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/spi_host_cmd_arb_pkg.sv
// Shared types and helpers for the multi-channel SPI host command arbiter.
package spi_host_cmd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    // Upper bound on channel count supported by the round-robin search.
    localparam int unsigned MaxCh = 32;

    // First set bit of req[n-1:0] searching upward from start, wrapping at n.
    // Returns start when nothing is requested (caller only uses it when |req).
    function automatic int unsigned rr_pick(input logic [MaxCh-1:0] req,
                                            input int unsigned      n,
                                            input int unsigned      start);
        int unsigned idx;
        logic        found;
        rr_pick = start;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < MaxCh; i++) begin
            if (i < n && !found) begin
                idx = start + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/spi_host_cmd_arb_fifo.sv
// Per-channel circular command FIFO with occupancy count and synchronous flush.
module spi_host_cmd_arb_fifo #(
    parameter  int unsigned Width = 65,
    parameter  int unsigned Depth = 4,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    // Guard against overflow/underflow locally even though the top qualifies both.
    assign do_push = push_i && (count_q != CntW'(Depth));
    assign do_pop  = pop_i  && (count_q != '0);

    // Pointer and occupancy bookkeeping; flush wins over any push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage array; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/spi_host_cmd_arbiter.sv
// Per-channel command queues arbitrated round-robin onto the SPI host core,
// keeping chip-select atomic across CSAAT segments with a stall timeout.
module spi_host_cmd_arbiter
    import spi_host_cmd_arb_pkg::*;
#(
    parameter  int unsigned NumCh       = 2,
    parameter  int unsigned CmdDepth    = 4,
    parameter  int unsigned CmdW        = 64,
    parameter  int unsigned LockTimeout = 1024,
    localparam int unsigned ChW         = (NumCh > 1) ? $clog2(NumCh) : 1,
    localparam int unsigned QdW         = $clog2(CmdDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sw_rst_i,
    input  logic [NumCh*CmdW-1:0] cmd_i,
    input  logic [NumCh-1:0]      cmd_csaat_i,
    input  logic [NumCh-1:0]      cmd_valid_i,
    output logic [NumCh-1:0]      busy_o,
    output logic [NumCh-1:0]      err_busy_o,
    output logic [NumCh*QdW-1:0]  qd_o,
    output logic [CmdW-1:0]       core_cmd_o,
    output logic                  core_csaat_o,
    output logic [ChW-1:0]        core_ch_o,
    output logic                  core_valid_o,
    input  logic                  core_ready_i,
    output logic                  locked_o,
    output logic                  lock_timeout_o
);

    localparam int unsigned TW = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;
    localparam logic [TW-1:0] ToLast = (LockTimeout > 0) ? TW'(LockTimeout - 1) : '0;

    arb_state_e       state_q, state_d;
    logic [ChW-1:0]   grant_q, grant_d, rr_q, rr_d, grant_nxt;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic [NumCh-1:0] full, nonempty, push, pop;
    logic [QdW-1:0]   cnt  [NumCh];
    logic [CmdW:0]    head [NumCh];
    logic [CmdW:0]    head_sel;
    logic [QdW-1:0]   grant_cnt;
    logic [MaxCh-1:0] req;
    logic             offer;

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        assign full[c]      = (cnt[c] == QdW'(CmdDepth));
        assign nonempty[c]  = (cnt[c] != '0);
        // Full check uses the registered count, so a same-cycle pop does not help.
        assign push[c]       = cmd_valid_i[c] && !full[c];
        assign busy_o[c]     = full[c];
        assign err_busy_o[c] = cmd_valid_i[c] && full[c] && !sw_rst_i;
        assign qd_o[c*QdW +: QdW] = cnt[c];

        spi_host_cmd_arb_fifo #(
            .Width (CmdW + 1),
            .Depth (CmdDepth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (sw_rst_i),
            .push_i  (push[c]),
            .data_i  ({cmd_csaat_i[c], cmd_i[c*CmdW +: CmdW]}),
            .pop_i   (pop[c]),
            .data_o  (head[c]),
            .count_o (cnt[c])
        );
    end

    assign req       = MaxCh'(nonempty);
    assign head_sel  = head[grant_q];
    assign grant_cnt = cnt[grant_q];
    assign grant_nxt = (grant_q == ChW'(NumCh - 1)) ? '0 : grant_q + 1'b1;

    // Core-facing outputs are zero whenever nothing is being offered.
    assign offer        = (state_q == OFFER);
    assign core_valid_o = offer;
    assign core_cmd_o   = offer ? head_sel[CmdW-1:0] : '0;
    assign core_csaat_o = offer ? head_sel[CmdW] : 1'b0;
    assign core_ch_o    = offer ? grant_q : '0;
    assign locked_o     = (state_q == LOCK);

    // Arbitration FSM: pick a channel, offer its head, hold grant across CSAAT.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        tmo_d          = tmo_q;
        pop            = '0;
        lock_timeout_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|nonempty) begin
                    grant_d = ChW'(rr_pick(req, NumCh, 32'(rr_q)));
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (core_ready_i) begin
                    pop[grant_q] = 1'b1;
                    if (!head_sel[CmdW]) begin
                        rr_d    = grant_nxt;
                        state_d = IDLE;
                    end else if (grant_cnt == QdW'(1)) begin
                        // CSAAT segment drained the queue: hold CS for this channel.
                        state_d = LOCK;
                        tmo_d   = '0;
                    end
                end
            end
            LOCK: begin
                if (nonempty[grant_q]) begin
                    state_d = OFFER;
                end else if (LockTimeout != 0 && tmo_q == ToLast) begin
                    lock_timeout_o = 1'b1;
                    rr_d           = grant_nxt;
                    state_d        = IDLE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers; software reset matches hardware reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            tmo_q   <= '0;
        end else if (sw_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
